// File: rtl/tl_debug_unit.sv
// Debug controller ahead of the MIPS pipeline: loads program bytes into IM, gates the pipeline, reports PC/cycle count over UART.
// Define DEBUG_STEP_EN to include single-step mode (STEP_WAIT/STEP_EXEC, CMD_STEP/CMD_NEXT).
module tl_debug_unit #(
  parameter int              LEN        = 32,
  parameter int              NB_ADDR_IM = 10,
  parameter logic [LEN-1:0]  HALT_CODE  = 32'hFFFFFFFF,
  parameter logic [7:0]      CMD_CONT   = 8'h43,
  parameter logic [7:0]      CMD_STEP   = 8'h53,
  parameter logic [7:0]      CMD_NEXT   = 8'h4E
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  input  logic [LEN-1:0]        i_pc,
  input  logic                  i_halt,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_im_wr_en,
  output logic [NB_ADDR_IM-1:0] o_im_wr_addr,
  output logic [LEN-1:0]        o_im_wr_data,
  output logic                  o_pipe_enable
);

  // Report bytes still to send after the first one (PC low bytes + full count).
  localparam int REP_W = LEN + 24;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_WAIT_MODE,
    ST_RUN_CONT,
`ifdef DEBUG_STEP_EN
    ST_STEP_WAIT,
    ST_STEP_EXEC,
`endif
    ST_SEND,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [NB_ADDR_IM-1:0] addr_q, addr_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [LEN-9:0]        shift_q, shift_d;
  logic [31:0]           cycle_cnt_q, cycle_cnt_d;
  logic [REP_W-1:0]      report_q, report_d;
  logic                  snap_q, snap_d;
  logic [2:0]            tx_idx_q, tx_idx_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  im_wr_en_q, im_wr_en_d;
  logic [NB_ADDR_IM-1:0] im_wr_addr_q, im_wr_addr_d;
  logic [LEN-1:0]        im_wr_data_q, im_wr_data_d;
  logic                  pipe_en_q, pipe_en_d;
  logic [LEN-1:0]        rx_word;
`ifdef DEBUG_STEP_EN
  logic                  final_q, final_d;
`else
  logic                  unused_step_cmds;
  assign unused_step_cmds = ^{CMD_STEP, CMD_NEXT};
`endif

  assign rx_word = {shift_q, i_rx_data};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    cycle_cnt_d  = cycle_cnt_q + {31'd0, pipe_en_q};
    report_d     = report_q;
    snap_d       = snap_q;
    tx_idx_d     = tx_idx_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    im_wr_en_d   = 1'b0;
    im_wr_addr_d = im_wr_addr_q;
    im_wr_data_d = im_wr_data_q;
    pipe_en_d    = pipe_en_q;
`ifdef DEBUG_STEP_EN
    final_d      = final_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (i_rx_done) begin
          shift_d    = rx_word[LEN-9:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            im_wr_en_d   = 1'b1;
            im_wr_addr_d = addr_q;
            im_wr_data_d = rx_word;
            addr_d       = addr_q + 1'b1;
            // The halt word and the last memory slot are both still written.
            if (rx_word == HALT_CODE || addr_q == '1) state_d = ST_WAIT_MODE;
          end
        end
      end
      ST_WAIT_MODE: begin
        if (i_rx_done && i_rx_data == CMD_CONT) begin
          pipe_en_d = 1'b1;
          state_d   = ST_RUN_CONT;
        end
`ifdef DEBUG_STEP_EN
        else if (i_rx_done && i_rx_data == CMD_STEP) begin
          state_d = ST_STEP_WAIT;
        end
`endif
      end
      ST_RUN_CONT: begin
        if (i_halt) begin
          pipe_en_d = 1'b0;
          snap_d    = 1'b1;
          state_d   = ST_SEND;
`ifdef DEBUG_STEP_EN
          final_d   = 1'b1;
`endif
        end
      end
`ifdef DEBUG_STEP_EN
      ST_STEP_WAIT: begin
        if (i_rx_done && i_rx_data == CMD_NEXT) begin
          pipe_en_d = 1'b1;
          state_d   = ST_STEP_EXEC;
        end
      end
      ST_STEP_EXEC: begin
        pipe_en_d = 1'b0;
        final_d   = i_halt;
        snap_d    = 1'b1;
        state_d   = ST_SEND;
      end
`endif
      ST_SEND: begin
        if (snap_q) begin
          snap_d     = 1'b0;
          report_d   = {i_pc[LEN-9:0], cycle_cnt_q};
          tx_idx_d   = 3'd0;
          tx_data_d  = i_pc[LEN-1 -: 8];
          tx_start_d = 1'b1;
        end else if (i_tx_done && !tx_start_q) begin
          // A done coinciding with our own start belongs to the previous byte.
          if (tx_idx_q == 3'd7) begin
`ifdef DEBUG_STEP_EN
            state_d = final_q ? ST_DONE : ST_STEP_WAIT;
`else
            state_d = ST_DONE;
`endif
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_data_d  = report_q[REP_W-1 -: 8];
            report_d   = {report_q[REP_W-9:0], 8'd0};
            tx_start_d = 1'b1;
          end
        end
      end
      ST_DONE: pipe_en_d = 1'b0;
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_LOAD;
      addr_q       <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      cycle_cnt_q  <= '0;
      report_q     <= '0;
      snap_q       <= 1'b0;
      tx_idx_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      im_wr_en_q   <= 1'b0;
      im_wr_addr_q <= '0;
      im_wr_data_q <= '0;
      pipe_en_q    <= 1'b0;
`ifdef DEBUG_STEP_EN
      final_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      cycle_cnt_q  <= cycle_cnt_d;
      report_q     <= report_d;
      snap_q       <= snap_d;
      tx_idx_q     <= tx_idx_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      im_wr_en_q   <= im_wr_en_d;
      im_wr_addr_q <= im_wr_addr_d;
      im_wr_data_q <= im_wr_data_d;
      pipe_en_q    <= pipe_en_d;
`ifdef DEBUG_STEP_EN
      final_q      <= final_d;
`endif
    end
  end

  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = tx_start_q;
  assign o_im_wr_en    = im_wr_en_q;
  assign o_im_wr_addr  = im_wr_addr_q;
  assign o_im_wr_data  = im_wr_data_q;
  assign o_pipe_enable = pipe_en_q;

endmodule

// File: tb/tb_tl_debug_unit.sv
// Directed bench for tl_debug_unit: load, mode commands, continuous run, reports with back-pressure, reset behaviour.
module tb_tl_debug_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic [31:0] pc;
  logic        halt;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pipe_en;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_n = 0, tx_n = 0, en_n = 0;
  int wr0, tx0, en0;

  tl_debug_unit dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_rx_data     (rx_data),
    .i_rx_done     (rx_done),
    .i_tx_done     (tx_done),
    .i_pc          (pc),
    .i_halt        (halt),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .o_im_wr_en    (wr_en),
    .o_im_wr_addr  (wr_addr),
    .o_im_wr_data  (wr_data),
    .o_pipe_enable (pipe_en)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (wr_en)    wr_n <= wr_n + 1;
    if (tx_start) tx_n <= tx_n + 1;
    if (pipe_en)  en_n <= en_n + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w, input logic [9:0] addr);
    logic [31:0] sh;
    sh = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(sh[31:24]);
      sh = sh << 8;
    end
    chk("im_wr_en_pulse", 64'(wr_en), 64'(1));
    chk("im_wr_addr", 64'(wr_addr), 64'(addr));
    chk("im_wr_data", 64'(wr_data), 64'(w));
    tick();
    chk("im_wr_en_clear", 64'(wr_en), 64'(0));
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    halt    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Called on the first SEND cycle; answers each byte after `gap` idle cycles.
  task automatic collect_report(input logic [63:0] rpt, input int gap);
    logic [63:0] sh;
    int extra;
    sh = rpt;
    chk("tx_entry_idle", 64'(tx_start), 64'(0));
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("tx_start", 64'(tx_start), 64'(1));
      chk("tx_byte", 64'(tx_data), 64'(sh[63:56]));
      sh = sh << 8;
      if (k == 0) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      extra = 0;
      repeat (gap) begin
        if (tx_start) extra++;
        tick();
      end
      chk("tx_no_overlap", 64'(extra), 64'(0));
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    chk("tx_after_last", 64'(tx_start), 64'(0));
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    pc      = 32'h0;
    halt    = 1'b0;
    tick();
    tick();
    chk("rst_tx", 64'({tx_data, tx_start}), 64'(0));
    chk("rst_im", 64'({wr_en, wr_addr, wr_data}), 64'(0));
    chk("rst_pipe", 64'(pipe_en), 64'(0));
    rst_n = 1'b1;
    tick();

    // Partial word then reset: the next full word must land at address 0.
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h00);
    tick();
    chk("partial_no_write", 64'(wr_n), 64'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    load_word(32'h20010005, 10'd0);
    load_word(32'h20020007, 10'd1);
    load_word(32'hFFFFFFFF, 10'd2);
    chk("load_write_count", 64'(wr_n), 64'(3));

    // In WAIT_MODE a full word of junk produces no write and no enable.
    en0 = en_n;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    tick();
    chk("wait_no_write", 64'(wr_n), 64'(3));
    chk("wait_no_enable", 64'(en_n - en0), 64'(0));

`ifdef DEBUG_STEP_EN
    send_byte(8'h53);
    tick();
    tick();
    chk("step_mode_idle", 64'(pipe_en), 64'(0));
    for (int j = 1; j <= 3; j++) begin
      pc   = 32'(4 * j);
      halt = (j == 3);
      en0  = en_n;
      tx0  = tx_n;
      send_byte(8'h4E);
      chk("step_pipe_on", 64'(pipe_en), 64'(1));
      tick();
      chk("step_pipe_off", 64'(pipe_en), 64'(0));
      collect_report({32'(4 * j), 32'(j)}, 2);
      tick();
      tick();
      chk("step_one_enable", 64'(en_n - en0), 64'(1));
      chk("step_tx_count", 64'(tx_n - tx0), 64'(8));
    end
    en0 = en_n;
    send_byte(8'h4E);
    repeat (3) tick();
    chk("step_done_ignores_next", 64'(en_n - en0), 64'(0));
    do_reset();
    load_word(32'hFFFFFFFF, 10'd0);
`else
    en0 = en_n;
    send_byte(8'h53);
    tick();
    tick();
    chk("nostep_53_pipe", 64'(pipe_en), 64'(0));
    send_byte(8'h4E);
    send_byte(8'h00);
    tick();
    chk("nostep_no_enable", 64'(en_n - en0), 64'(0));
`endif

    // Continuous run: 10 enabled cycles with halt low, halt seen on the 11th.
    wr0  = wr_n;
    tx0  = tx_n;
    en0  = en_n;
    halt = 1'b0;
    send_byte(8'h43);
    chk("cont_pipe_on", 64'(pipe_en), 64'(1));
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    chk("cont_stray_no_write", 64'(wr_n - wr0), 64'(0));
    chk("cont_stray_still_on", 64'(pipe_en), 64'(1));
    repeat (6) tick();
    chk("cont_pipe_before_halt", 64'(pipe_en), 64'(1));
    pc   = 32'h0000000C;
    halt = 1'b1;
    tick();
    chk("cont_pipe_drop", 64'(pipe_en), 64'(0));
    chk("cont_enabled_cycles", 64'(en_n - en0), 64'(11));
    collect_report(64'h0000000C_0000000B, 20);
    chk("cont_tx_count", 64'(tx_n - tx0), 64'(8));

    // DONE: commands, rx bytes and tx_done are all ignored.
    en0 = en_n;
    tx0 = tx_n;
    send_byte(8'h43);
    send_byte(8'h53);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (5) tick();
    chk("done_pipe_off", 64'(pipe_en), 64'(0));
    chk("done_no_enable", 64'(en_n - en0), 64'(0));
    chk("done_no_tx", 64'(tx_n - tx0), 64'(0));
    chk("done_no_write", 64'(wr_n - wr0), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
